ppfifo_pattern_checker: RTL and testbench

Consumes the read side of a ping-pong FIFO, such as the memory-to-FIFO path of the test DMA memory device, and checks that the stream is an incrementing address pattern that wraps at 2^ADDRESS_WIDTH. It owns the FIFO read handshake (activate/strobe) and counts the words it checks. It reports a sticky error, an error count and details of the first mismatch to the DMA test harness.

---
 rtl/ppfifo_pattern_checker.sv | 192 +++++++++++++++++++
 tb/tb_ppfifo_pattern_checker.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppfifo_pattern_checker.sv
// ppfifo_pattern_checker: drains a ping-pong FIFO read port and checks the
// stream against an incrementing address pattern that wraps at 2^ADDRESS_WIDTH.
module ppfifo_pattern_checker #(
    parameter int ADDRESS_WIDTH   = 8,
    parameter int ERR_COUNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [31:0]                start_value,
    input  logic [23:0]                word_count,
    input  logic                       read_ready,
    output logic                       read_activate,
    input  logic [23:0]                read_size,
    input  logic [31:0]                read_data,
    output logic                       read_strobe,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [ERR_COUNT_WIDTH-1:0] error_count,
    output logic [23:0]                words_checked,
    output logic [23:0]                first_err_index,
    output logic [31:0]                first_err_expected,
    output logic [31:0]                first_err_actual
);

    localparam logic [31:0] ADDR_MASK = (32'd1 << ADDRESS_WIDTH) - 32'd1;
    localparam logic [ERR_COUNT_WIDTH-1:0] ERR_MAX = '1;
    localparam logic [ERR_COUNT_WIDTH-1:0] ERR_ONE = ERR_COUNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        GRAB,
        SETTLE,
        CHECK,
        POP,
        RELEASE,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        enable_q;
    logic        enable_rise;
    logic        abort;
    logic        mismatch;
    logic        run_complete;
    logic        buf_complete;
    logic [31:0] expected;
    logic [31:0] expected_next;
    logic [23:0] target;
    logic [23:0] buf_count;

    assign enable_rise  = enable && !enable_q;
    assign abort        = !enable && (state != IDLE) && (state != DONE);
    assign mismatch     = (read_data != expected);
    assign run_complete = (words_checked == target);
    assign buf_complete = (buf_count == read_size);
    assign busy         = (state != IDLE) && (state != DONE);

    // Pattern successor: wrap to zero at the top of the address space
    always_comb begin
        expected_next = 32'd0;
        if (expected != ADDR_MASK) begin
            expected_next = (expected + 32'd1) & ADDR_MASK;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a low enable mid-run always falls back to IDLE
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (enable_rise) begin
                        state_next = (word_count == 24'd0) ? DONE : GRAB;
                    end
                end
                GRAB: begin
                    if (read_ready && !read_activate) begin
                        state_next = SETTLE;
                    end
                end
                SETTLE: begin
                    state_next = (read_size == 24'd0) ? RELEASE : CHECK;
                end
                CHECK: begin
                    state_next = POP;
                end
                POP: begin
                    if (run_complete || buf_complete) begin
                        state_next = RELEASE;
                    end else begin
                        state_next = CHECK;
                    end
                end
                RELEASE: begin
                    state_next = run_complete ? DONE : GRAB;
                end
                DONE: begin
                    if (!enable) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Datapath: handshake outputs, pattern tracking and error capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q           <= 1'b0;
            read_activate      <= 1'b0;
            read_strobe        <= 1'b0;
            done               <= 1'b0;
            error              <= 1'b0;
            error_count        <= '0;
            words_checked      <= 24'd0;
            first_err_index    <= 24'd0;
            first_err_expected <= 32'd0;
            first_err_actual   <= 32'd0;
            expected           <= 32'd0;
            target             <= 24'd0;
            buf_count          <= 24'd0;
        end else begin
            enable_q    <= enable;
            read_strobe <= 1'b0;
            done        <= (state == DONE) && enable;
            if (abort) begin
                read_activate <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (enable_rise) begin
                            expected           <= start_value;
                            target             <= word_count;
                            words_checked      <= 24'd0;
                            error              <= 1'b0;
                            error_count        <= '0;
                            first_err_index    <= 24'd0;
                            first_err_expected <= 32'd0;
                            first_err_actual   <= 32'd0;
                        end
                    end
                    GRAB: begin
                        if (read_ready && !read_activate) begin
                            read_activate <= 1'b1;
                            buf_count     <= 24'd0;
                        end
                    end
                    CHECK: begin
                        if (mismatch) begin
                            error <= 1'b1;
                            if (error_count != ERR_MAX) begin
                                error_count <= error_count + ERR_ONE;
                            end
                            if (!error) begin
                                first_err_index    <= words_checked;
                                first_err_expected <= expected;
                                first_err_actual   <= read_data;
                            end
                        end
                        words_checked <= words_checked + 24'd1;
                        buf_count     <= buf_count + 24'd1;
                        expected      <= expected_next;
                        read_strobe   <= 1'b1;
                    end
                    RELEASE: begin
                        read_activate <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppfifo_pattern_checker.sv
// tb_ppfifo_pattern_checker: ping-pong FIFO read-side model plus a
// scoreboard of expected popped words and per-run results.
module tb_ppfifo_pattern_checker;

    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] start_value;
    logic [23:0] word_count;
    logic        read_ready;
    logic        read_activate;
    logic [23:0] read_size;
    logic [31:0] read_data;
    logic        read_strobe;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] error_count;
    logic [23:0] words_checked;
    logic [23:0] first_err_index;
    logic [31:0] first_err_expected;
    logic [31:0] first_err_actual;

    ppfifo_pattern_checker #(
        .ADDRESS_WIDTH  (AW),
        .ERR_COUNT_WIDTH(16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .start_value       (start_value),
        .word_count        (word_count),
        .read_ready        (read_ready),
        .read_activate     (read_activate),
        .read_size         (read_size),
        .read_data         (read_data),
        .read_strobe       (read_strobe),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .error_count       (error_count),
        .words_checked     (words_checked),
        .first_err_index   (first_err_index),
        .first_err_expected(first_err_expected),
        .first_err_actual  (first_err_actual)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          bufi;
        logic [31:0] data;
    } word_t;

    typedef struct {
        logic [23:0] words;
        logic        err;
        logic [15:0] cnt;
        logic [23:0] idx;
        logic [31:0] fexp;
        logic [31:0] fact;
    } res_t;

    word_t wq[$];
    res_t  rq[$];

    int n_chk = 0;
    int n_fail = 0;

    // FIFO model state
    int          nbuf = 0;
    int          bsize [8];
    logic [31:0] bdata [8][64];
    int          cur = 0;
    int          ptr = 0;
    logic        act_q = 1'b0;
    logic        fifo_clr;

    // Monitor state
    int    strobe_cnt = 0;
    logic  prev_strobe = 1'b0;
    logic  act_seen = 1'b0;
    word_t mon_w;
    int    last_lat;
    int    last_act;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] e);
        logic [31:0] m;
        m = (32'd1 << AW) - 32'd1;
        return (e == m) ? 32'd0 : ((e + 32'd1) & m);
    endfunction

    // A buffer is not offered again in the cycle its release is seen
    assign read_ready = (cur < nbuf) && !(act_q && !read_activate);
    assign read_size  = (read_activate && cur < nbuf) ? 24'(bsize[cur]) : 24'd0;
    assign read_data  = (cur < nbuf && ptr < 64) ? bdata[cur][ptr] : 32'd0;

    always @(posedge clk) begin
        act_q <= read_activate;
        if (fifo_clr) begin
            cur <= 0;
            ptr <= 0;
        end else if (act_q && !read_activate) begin
            cur <= cur + 1;
            ptr <= 0;
        end else if (read_strobe) begin
            ptr <= ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (read_activate) act_seen = 1'b1;
        if (read_strobe) begin
            strobe_cnt++;
            chk("strobe_act", 32'(read_activate), 1);
            chk("strobe_b2b", 32'(prev_strobe), 0);
            chk("sb_nonempty", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
                mon_w = wq.pop_front();
                chk("sb_buf", cur, mon_w.bufi);
                chk("sb_data", read_data, mon_w.data);
            end
        end
        prev_strobe = read_strobe;
    end

    task automatic clear_fifo();
        @(negedge clk);
        nbuf     = 0;
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
    endtask

    task automatic add_buf(input int sz, input int first);
        bsize[nbuf] = sz;
        for (int i = 0; i < 64; i++) begin
            bdata[nbuf][i] = 32'(first + i);
        end
        nbuf++;
    endtask

    task automatic kick(input logic [31:0] sv, input int wc);
        @(negedge clk);
        #1;
        start_value = sv;
        word_count  = 24'(wc);
        enable      = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_act"}, 32'(read_activate), 0);
        chk({tag, "_stb"}, 32'(read_strobe), 0);
        chk({tag, "_err"}, 32'(error), 0);
        chk({tag, "_ecnt"}, 32'(error_count), 0);
        chk({tag, "_words"}, 32'(words_checked), 0);
        chk({tag, "_fidx"}, 32'(first_err_index), 0);
        chk({tag, "_fexp"}, first_err_expected, 0);
        chk({tag, "_fact"}, first_err_actual, 0);
    endtask

    // Push expected words/results, run to done, compare, then drop enable
    task automatic run(input string tag, input logic [31:0] sv, input int wc);
        int          rem;
        int          n;
        int          k;
        logic [31:0] e;
        word_t       w;
        res_t        r;
        res_t        got;
        rem = wc;
        k   = 0;
        e   = sv;
        r   = '{words: 0, err: 0, cnt: 0, idx: 0, fexp: 0, fact: 0};
        for (int b = 0; b < nbuf && rem > 0; b++) begin
            n = (bsize[b] < rem) ? bsize[b] : rem;
            for (int i = 0; i < n; i++) begin
                w.bufi = b;
                w.data = bdata[b][i];
                wq.push_back(w);
                if (w.data != e) begin
                    if (r.cnt == 0) begin
                        r.idx  = 24'(k);
                        r.fexp = e;
                        r.fact = w.data;
                    end
                    r.cnt = r.cnt + 16'd1;
                    r.err = 1'b1;
                end
                e = nxt(e);
                k++;
            end
            rem -= n;
        end
        r.words = 24'(k);
        rq.push_back(r);
        kick(sv, wc);
        last_lat = 0;
        last_act = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            #1;
            if (read_activate && last_act == 0) last_act = c;
            if (done) begin
                last_lat = c;
                break;
            end
        end
        chk({tag, "_done"}, 32'(done), 1);
        got = rq.pop_front();
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_words"}, 32'(words_checked), 32'(got.words));
        chk({tag, "_err"}, 32'(error), 32'(got.err));
        chk({tag, "_ecnt"}, 32'(error_count), 32'(got.cnt));
        chk({tag, "_fidx"}, 32'(first_err_index), 32'(got.idx));
        chk({tag, "_fexp"}, first_err_expected, got.fexp);
        chk({tag, "_fact"}, first_err_actual, got.fact);
        chk({tag, "_sbq"}, wq.size(), 0);
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk({tag, "_done_clr"}, 32'(done), 0);
        chk({tag, "_keep"}, 32'(words_checked), 32'(got.words));
    endtask

    task automatic wait_strobes(input string tag, input int target);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            #1;
            if (strobe_cnt >= target) break;
        end
        chk({tag, "_wait"}, 32'(strobe_cnt >= target), 1);
    endtask

    initial begin
        int s0;
        word_t w;
        rst_n       = 1'b0;
        enable      = 1'b0;
        start_value = 32'd0;
        word_count  = 24'd0;
        fifo_clr    = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n    = 1'b1;
        fifo_clr = 1'b0;

        // Single buffer, no errors
        clear_fifo();
        add_buf(16, 0);
        s0 = strobe_cnt;
        run("single", 32'd0, 16);
        chk("single_strobes", strobe_cnt - s0, 16);
        chk("single_act_lat", last_act, 2);

        // Wrap-around, clean
        clear_fifo();
        add_buf(4, 0);
        bdata[0][0] = 32'hFE;
        bdata[0][1] = 32'hFF;
        bdata[0][2] = 32'h00;
        bdata[0][3] = 32'h01;
        run("wrap_ok", 32'hFE, 4);

        // Wrap-around, data runs past the address width
        clear_fifo();
        add_buf(4, 32'hFE);
        run("wrap_bad", 32'hFE, 4);
        chk("wrap_bad_idx2", 32'(first_err_index), 2);
        chk("wrap_bad_act", first_err_actual, 32'h100);

        // Two buffers, second only partly consumed
        clear_fifo();
        add_buf(8, 0);
        add_buf(8, 8);
        run("multi", 32'd0, 12);
        chk("multi_released", cur, 2);

        // Single injected fault, checking resynchronises
        clear_fifo();
        add_buf(10, 0);
        bdata[0][5] = 32'h55;
        run("fault", 32'd0, 10);
        chk("fault_cnt1", 32'(error_count), 1);
        chk("fault_idx5", 32'(first_err_index), 5);

        // Empty run: done after two cycles, no activate
        clear_fifo();
        add_buf(4, 0);
        act_seen = 1'b0;
        run("empty", 32'd0, 0);
        chk("empty_lat", last_lat, 2);
        chk("empty_noact", 32'(act_seen), 0);

        // Zero-size buffer is released without a strobe
        clear_fifo();
        add_buf(0, 0);
        add_buf(4, 0);
        run("zsize", 32'd0, 4);
        chk("zsize_released", cur, 2);

        // Abort after three words
        clear_fifo();
        add_buf(16, 0);
        for (int i = 0; i < 3; i++) begin
            w.bufi = 0;
            w.data = 32'(i);
            wq.push_back(w);
        end
        s0 = strobe_cnt;
        kick(32'd0, 16);
        wait_strobes("abort", s0 + 3);
        enable = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_act", 32'(read_activate), 0);
        chk("abort_stb", 32'(read_strobe), 0);
        chk("abort_idle", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_words", 32'(words_checked), 3);
        repeat (3) @(negedge clk);
        #1;
        chk("abort_done_later", 32'(done), 0);
        chk("abort_sbq", wq.size(), 0);

        // Asynchronous reset in the middle of a buffer
        clear_fifo();
        add_buf(16, 0);
        bdata[0][0] = 32'h77;
        w.bufi = 0;
        w.data = 32'h77;
        wq.push_back(w);
        w.data = 32'd1;
        wq.push_back(w);
        s0 = strobe_cnt;
        kick(32'd0, 16);
        wait_strobes("rst", s0 + 2);
        chk("rst_pre_err", 32'(error), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_sbq", wq.size(), 0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
